// File: rtl/pi_bridge_pkg.sv
// Shared types and constants for the Pi-side SPI register bridge.
package pi_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddrHi,
    StAddrLo,
    StData
  } bridge_state_e;

  localparam int unsigned CMD_WRITE_BIT = 7;
  localparam logic [15:0] KBD_BASE_ADDR = 16'hE800;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for an asynchronous pin, with single-cycle rise/fall pulses
// derived from the synchronized level.
module sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter bit          ResetVal = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= (sync_q << 1) | Stages'(d_i);
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/pi_spi_bridge.sv
// SPI mode-0 target that decodes CMD/ADDR_HI/ADDR_LO/DATA frames into the
// Pi-side parallel register bus, with prefetching burst reads.
module pi_spi_bridge
  import pi_bridge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_cs_n,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [15:0] pi_addr,
  output logic [7:0]  pi_data,
  output logic        pi_write_strobe,
  output logic        pi_read_strobe,
  input  logic [7:0]  pi_rd_data
);

  logic sck_rise, sck_fall, sck_unused;
  logic cs_rise, cs_fall, cs_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sck (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (spi_sck),
    .q_o     (sck_unused),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  // Resetting CS low means a frame still in flight after reset never looks
  // like a fresh falling edge.
  sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_cs (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (spi_cs_n),
    .q_o     (cs_unused),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (spi_mosi),
    .q_o     (mosi_s),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  bridge_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        is_write_q, is_write_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wr_stb_q, wr_stb_d;
  logic        rd_stb_q, rd_stb_d;
  logic        cap_q, cap_d;
  logic [7:0]  rx_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      miso_q     <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= 16'h0000;
      data_q     <= 8'h00;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      cap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
      cap_q      <= cap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_stb_d   = 1'b0;
    rd_stb_d   = 1'b0;
    cap_d      = rd_stb_q;
    rx_byte    = {rx_q[6:0], mosi_s};

    if (wr_stb_q) begin
      addr_d = addr_q + 16'd1;
    end
    // Prefetch capture is dropped once the frame has ended.
    if (cap_q && (state_q != StIdle)) begin
      tx_d   = pi_rd_data;
      miso_d = pi_rd_data[7];
      addr_d = addr_q + 16'd1;
    end

    if (cs_rise || cs_fall) begin
      state_d   = cs_rise ? StIdle : StCmd;
      bit_cnt_d = 3'd0;
      rx_d      = 8'h00;
      tx_d      = 8'h00;
      miso_d    = 1'b0;
    end else if (state_q != StIdle) begin
      // miso takes tx[7] before the shift, so a freshly loaded MSB survives
      // the falling edge that follows the previous byte's last rising edge.
      if (sck_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (sck_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            StCmd: begin
              is_write_d = rx_byte[CMD_WRITE_BIT];
              state_d    = StAddrHi;
            end
            StAddrHi: begin
              addr_d[15:8] = rx_byte;
              state_d      = StAddrLo;
            end
            StAddrLo: begin
              addr_d[7:0] = rx_byte;
              rd_stb_d    = ~is_write_q;
              state_d     = StData;
            end
            StData: begin
              if (is_write_q) begin
                data_d   = rx_byte;
                wr_stb_d = 1'b1;
              end else begin
                rd_stb_d = 1'b1;
              end
            end
            default: state_d = StIdle;
          endcase
        end
      end
    end
  end

  assign spi_miso        = miso_q;
  assign pi_addr         = addr_q;
  assign pi_data         = data_q;
  assign pi_write_strobe = wr_stb_q;
  assign pi_read_strobe  = rd_stb_q;

endmodule

// File: tb/tb_pi_spi_bridge.sv
// Directed-plus-random bench for pi_spi_bridge: an SPI master drives frames and
// the logged bus strobes and MISO bytes are checked against expected transactions.
module tb_pi_spi_bridge;
  import pi_bridge_pkg::*;

  localparam int HALF = 8;  // clk cycles per SCK half period (SCK = clk/16)

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [15:0] pi_addr;
  logic [7:0]  pi_data;
  logic        pi_write_strobe;
  logic        pi_read_strobe;
  logic [7:0]  pi_rd_data = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pi_spi_bridge #(.SYNC_STAGES(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .spi_cs_n        (spi_cs_n),
    .spi_sck         (spi_sck),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso),
    .pi_addr         (pi_addr),
    .pi_data         (pi_data),
    .pi_write_strobe (pi_write_strobe),
    .pi_read_strobe  (pi_read_strobe),
    .pi_rd_data      (pi_rd_data)
  );

  // Bus-side log and read responder; a strobe wider than one clk shows up as
  // an extra logged transaction.
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [15:0] rd_addr_q[$];
  logic [7:0]  rd_vals[$];
  int          overlap_cnt = 0;

  always @(negedge clk) begin
    if (pi_write_strobe && pi_read_strobe) overlap_cnt++;
    if (pi_write_strobe) begin
      wr_addr_q.push_back(pi_addr);
      wr_data_q.push_back(pi_data);
    end
    if (pi_read_strobe) begin
      rd_addr_q.push_back(pi_addr);
      pi_rd_data = (rd_vals.size() > 0) ? rd_vals.pop_front() : 8'($urandom);
    end
  end

  logic [7:0] tx_buf[16];
  logic [7:0] rx_buf[16];
  logic [7:0] rd_exp[8];
  logic [7:0] kbd[10];
  logic [7:0] scratch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    rd_vals.delete();
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r, input int nbits);
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (HALF) @(negedge clk);
      r = {r[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_frame(input int n);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < n; i++) spi_byte(tx_buf[i], rx_buf[i], 8);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  // Data bytes must already be in tx_buf[3..].
  task automatic write_frame(input string tag, input logic [15:0] a, input int n);
    tx_buf[0] = {1'b1, 7'($urandom)};
    tx_buf[1] = a[15:8];
    tx_buf[2] = a[7:0];
    clear_logs();
    send_frame(n + 3);
    check($sformatf("%s wr_count", tag), wr_addr_q.size(), n);
    check($sformatf("%s rd_count", tag), rd_addr_q.size(), 0);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s addr%0d", tag, i), wr_addr_q[i], 16'(a + 16'(i)));
      check($sformatf("%s data%0d", tag, i), wr_data_q[i], tx_buf[3 + i]);
    end
  endtask

  // Values returned by the bus are in rd_exp[0..n-1]; one more is prefetched.
  task automatic read_frame(input string tag, input logic [15:0] a, input int n);
    tx_buf[0] = {1'b0, 7'($urandom)};
    tx_buf[1] = a[15:8];
    tx_buf[2] = a[7:0];
    clear_logs();
    for (int i = 0; i < n; i++) begin
      tx_buf[3 + i] = 8'($urandom);
      rd_vals.push_back(rd_exp[i]);
    end
    rd_vals.push_back(8'($urandom));
    send_frame(n + 3);
    check($sformatf("%s rd_count", tag), rd_addr_q.size(), n + 1);
    check($sformatf("%s wr_count", tag), wr_addr_q.size(), 0);
    for (int i = 0; i < 3; i++) check($sformatf("%s miso_hdr%0d", tag, i), rx_buf[i], 8'h00);
    for (int i = 0; i <= n && i < rd_addr_q.size(); i++)
      check($sformatf("%s rd_addr%0d", tag, i), rd_addr_q[i], 16'(a + 16'(i)));
    for (int i = 0; i < n; i++) check($sformatf("%s miso%0d", tag, i), rx_buf[3 + i], rd_exp[i]);
  endtask

  initial begin
    logic [15:0] ra;
    int          rn;

    for (int i = 0; i < 10; i++) kbd[i] = 8'h00;

    repeat (4) @(negedge clk);
    check("reset addr", pi_addr, 16'h0000);
    check("reset data", pi_data, 8'h00);
    check("reset wstb", pi_write_strobe, 1'b0);
    check("reset rstb", pi_read_strobe, 1'b0);
    check("reset miso", spi_miso, 1'b0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single write into the keyboard row window.
    tx_buf[3] = 8'h08;
    write_frame("single", 16'hE803, 1);
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] - KBD_BASE_ADDR < 16'd10) kbd[wr_addr_q[i] - KBD_BASE_ADDR] = wr_data_q[i];
    check("kbd row3", kbd[3], 8'h08);

    // Burst across all ten keyboard rows.
    for (int i = 0; i < 10; i++) tx_buf[3 + i] = 8'(1 << (i % 8));
    write_frame("burst", KBD_BASE_ADDR, 10);

    // Read burst with the returned bytes from the test plan.
    rd_exp[0] = 8'h5A;
    rd_exp[1] = 8'hA5;
    read_frame("read", 16'hE805, 2);

    // Abort mid data byte, then a clean frame.
    clear_logs();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'h80, scratch, 8);
    spi_byte(8'h12, scratch, 8);
    spi_byte(8'h34, scratch, 8);
    spi_byte(8'($urandom), scratch, 4);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    check("abort wr_count", wr_addr_q.size(), 0);
    check("abort rd_count", rd_addr_q.size(), 0);
    tx_buf[3] = 8'h56;
    write_frame("post_abort", 16'h1234, 1);

    // 16-bit address wrap.
    tx_buf[3] = 8'($urandom);
    tx_buf[4] = 8'($urandom);
    write_frame("wrap", 16'hFFFF, 2);

    // Randomized frames.
    for (int k = 0; k < 3; k++) begin
      ra = 16'($urandom);
      rn = 1 + int'($urandom_range(3));
      for (int i = 0; i < rn; i++) tx_buf[3 + i] = 8'($urandom);
      write_frame($sformatf("rwr%0d", k), ra, rn);
    end
    for (int k = 0; k < 2; k++) begin
      ra = 16'($urandom);
      rn = 1 + int'($urandom_range(2));
      for (int i = 0; i < rn; i++) rd_exp[i] = 8'($urandom);
      read_frame($sformatf("rrd%0d", k), ra, rn);
    end

    // Reset asserted during ADDR_LO.
    clear_logs();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'h80, scratch, 8);
    spi_byte(8'hE8, scratch, 8);
    spi_byte(8'h02, scratch, 3);
    reset_n = 1'b0;
    #1;
    check("mid reset addr", pi_addr, 16'h0000);
    check("mid reset data", pi_data, 8'h00);
    check("mid reset wstb", pi_write_strobe, 1'b0);
    check("mid reset rstb", pi_read_strobe, 1'b0);
    check("mid reset miso", spi_miso, 1'b0);
    spi_cs_n = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    check("mid reset wr_count", wr_addr_q.size(), 0);
    check("mid reset addr held", pi_addr, 16'h0000);
    tx_buf[3] = 8'($urandom);
    write_frame("post_reset", 16'hE809, 1);

    check("strobe overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pi_spi_bridge.md
# pi_spi_bridge

SPI target that turns byte-framed commands from the Raspberry Pi into the parallel Pi-side register bus: `pi_addr`, `pi_data`, `pi_write_strobe`, plus a read path. It sits directly upstream of `keyboard` and any other Pi-writable register block. The Pi uses it to write key-matrix rows at 0xE800–0xE809 and to read back state. SPI lines are asynchronous to `clk` and are oversampled.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `spi_cs_n`, `spi_sck` and `spi_mosi`.
- `clk`  in  1  system clock. One clock; every flop is in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `spi_cs_n`  in  1  chip select, active low, async.
- `spi_sck`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), async, at most clk/8.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out, MSB first.
- `pi_addr`  out  16  register address; stable whenever either strobe is high.
- `pi_data`  out  8  write data; valid with `pi_write_strobe`.
- `pi_write_strobe`  out  1  one-cycle write pulse.
- `pi_read_strobe`  out  1  one-cycle read-request pulse.
- `pi_rd_data`  in  8  read data; sampled the cycle after `pi_read_strobe`.

## Operation
- Frame: CS falls, then CMD byte, ADDR_HI, ADDR_LO, then 0..N data bytes, then CS rises.
- CMD bit 7: 1 = write, 0 = read. Bits 6:0 are ignored.
- States: IDLE → CMD → ADDR_HI → ADDR_LO → DATA, with DATA looping on itself.
  - Each transition happens on completion of 8 bits.
  - CS high forces IDLE from any state.
- Bit capture: on each synchronized SCK rising edge, sample MOSI into the rx shift register and increment the 3-bit bit counter. A count wrap marks byte complete.
- Write, per completed DATA byte:
  - `pi_data` = byte; `pi_write_strobe` = 1 for one cycle at the current `pi_addr`.
  - `pi_addr` increments the cycle after the strobe.
- Read:
  - On ADDR_LO completion, pulse `pi_read_strobe`.
  - Next cycle, load `pi_rd_data` into the tx shift register, then increment `pi_addr`.
  - Repeat on each completed DATA byte, which prefetches the next address.
- MISO: on each synchronized SCK falling edge, shift tx left; `spi_miso` = tx[7].
  - On a tx load, `spi_miso` = new tx[7] immediately.
  - During CMD and the address bytes, and throughout write frames, tx = 0x00.
- Address arithmetic: 16-bit, 0xFFFF+1 wraps to 0x0000.
- Abort: CS rising mid-byte discards the partial byte. No strobe is issued, and the bit counter and tx clear.
  - A strobe already issued is not retracted.
  - A read prefetch pending when CS rises is still captured, but the capture has no effect.
- CS falling while not IDLE (glitch) restarts at CMD.
- Reset values: `pi_addr` 0x0000, `pi_data` 0x00, both strobes 0, `spi_miso` 0, state IDLE, bit counter 0, tx and rx 0x00.
- Reset mid-frame: all outputs return to reset values. The frame is dropped, and the bridge waits for the next CS falling edge.

## Timing
- Input latency: an SCK edge is acted on `SYNC_STAGES`+1 clk after the pin transition.
- Write strobe: 1 clk after byte-complete detection; exactly 1 clk wide.
- Read: strobe 1 clk after byte complete; capture 1 clk later; MISO valid 2 clk after byte complete. This must precede the next SCK falling edge, which holds for SCK ≤ clk/8.
- Strobes never overlap. At most one strobe per byte.
- Back-to-back bytes: minimum spacing is 8 SCK periods, which is always ≥ 64 clk.

## Structure
- Package `pi_bridge_pkg` holds:
  - state encodings (IDLE, CMD, ADDR_HI, ADDR_LO, DATA);
  - `CMD_WRITE_BIT` = 7;
  - `KBD_BASE_ADDR` = 16'hE800.
- One sub-module, `sync_edge`: an N-stage synchronizer with rise/fall pulse outputs. Instantiate it for `spi_sck` and `spi_cs_n`; use its synchronizer-only output for `spi_mosi`.
- The top module contains the FSM, shift registers, address counter and strobe generation.

## Test plan
- Single write: bytes 0x80, 0xE8, 0x03, 0x08 → exactly one `pi_write_strobe`, with `pi_addr` = 0xE803 and `pi_data` = 0x08. Feeding the outputs to `keyboard` gives row 3 reading 0x08.
- Burst write: 0x80, 0xE8, 0x00, then data 0x01, 0x02, 0x04 … 0x80, 0x01, 0x02 → 10 strobes at addresses 0xE800–0xE809 with matching data, each 1 clk wide.
- Read burst: 0x00, 0xE8, 0x05, then 2 dummy bytes, with the bench returning 0x5A then 0xA5 → MISO bytes 0x5A, 0xA5. Read strobes land at 0xE805, 0xE806 and 0xE807 (prefetch).
- Abort: write frame with CS raised after 4 data bits → no strobe. The following full frame 0x80, 0x12, 0x34, 0x56 → one strobe at 0x1234 with data 0x56.
- Wrap: write to 0xFFFF with 2 data bytes → strobes at 0xFFFF then 0x0000.
- Reset: assert `reset_n` low during ADDR_LO → all outputs at reset values within 0 clk (asynchronous), no strobe. After release, the next frame decodes correctly.
